// File: rtl/arm_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arm_mem_pkg: FSM encoding and default geometry for the MEM/SRAM path |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package arm_mem_pkg;

    localparam int C_DATA_W      = 32;
    localparam int C_SRAM_DQ_W   = 16;
    localparam int C_SRAM_ADDR_W = 18;
    localparam int C_BASE_ADDR   = 1024;
    localparam int C_WAIT_CYCLES = 1;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_LOW  = 2'd1;
    localparam logic [1:0] C_ST_HIGH = 2'd2;
    localparam logic [1:0] C_ST_DONE = 2'd3;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_wait_counter: per-phase hold counter, terminal count each      |
// | WAIT_CYCLES+1 cycles while not cleared.  Rev 1.0                   |
// +--------------------------------------------------------------------+
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tc_o
);

    generate
        if (WAIT_CYCLES == 0) begin : g_no_wait
            logic w_unused;
            assign w_unused = ^{clk, rst, clear_i};
            assign tc_o     = 1'b1;
        end else begin : g_wait
            localparam int C_CW = $clog2(WAIT_CYCLES + 1);
            logic [C_CW-1:0] cnt_q;

            // Wraps on terminal count so LOW and HIGH share one counter back to back.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else if (clear_i || tc_o) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + C_CW'(1);
                end
            end

            assign tc_o = (cnt_q == C_CW'(WAIT_CYCLES));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/arm_sram_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arm_sram_controller: 32-bit MEM-stage loads/stores served as two    |
// | 16-bit async SRAM half-word phases.  Rev 1.0                       |
// +--------------------------------------------------------------------+
module arm_sram_controller
    import arm_mem_pkg::*;
#(
    parameter int DATA_W      = C_DATA_W,
    parameter int SRAM_DQ_W   = C_SRAM_DQ_W,
    parameter int SRAM_ADDR_W = C_SRAM_ADDR_W,
    parameter int BASE_ADDR   = C_BASE_ADDR,
    parameter int WAIT_CYCLES = C_WAIT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [DATA_W-1:0]      address,
    input  logic [DATA_W-1:0]      write_data,
    output logic [DATA_W-1:0]      read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DQ_W-1:0]   sram_dq_o,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DQ_W-1:0]   sram_dq_i,
    output logic                   sram_we_n
);

    logic [1:0]             state_q, state_d;
    op_e                    op_q;
    logic [SRAM_ADDR_W-1:0] h0_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      rdata_q;

    logic                   w_req;
    logic                   w_tc;
    logic                   w_active;
    logic [DATA_W-1:0]      w_offset;
    logic                   w_unused_offset;

    assign w_req    = wr_en | rd_en;
    assign w_active = (state_q == C_ST_LOW) || (state_q == C_ST_HIGH);
    assign w_offset = address - DATA_W'(BASE_ADDR);
    // Only the word-index bits survive truncation; out-of-range addresses simply wrap.
    assign w_unused_offset = ^{w_offset[DATA_W-1:SRAM_ADDR_W+1], w_offset[1:0]};

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clear_i (~w_active),
        .tc_o    (w_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (w_req) state_d = C_ST_LOW;
            C_ST_LOW:  if (w_tc)  state_d = C_ST_HIGH;
            C_ST_HIGH: if (w_tc)  state_d = C_ST_DONE;
            default:              state_d = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= C_ST_IDLE;
            op_q    <= OP_READ;
            h0_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == C_ST_IDLE && w_req) begin
                op_q    <= wr_en ? OP_WRITE : OP_READ;
                h0_q    <= {w_offset[SRAM_ADDR_W:2], 1'b0};
                wdata_q <= write_data;
            end
        end
    end

    // SRAM data is sampled on the final cycle of each read phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (op_q == OP_READ && w_tc) begin
            if (state_q == C_ST_LOW) begin
                rdata_q[SRAM_DQ_W-1:0] <= sram_dq_i;
            end else if (state_q == C_ST_HIGH) begin
                rdata_q[DATA_W-1:SRAM_DQ_W] <= sram_dq_i;
            end
        end
    end

    always_comb begin
        sram_addr = '0;
        sram_dq_o = '0;
        if (state_q == C_ST_LOW) begin
            sram_addr = h0_q;
        end else if (state_q == C_ST_HIGH) begin
            sram_addr = {h0_q[SRAM_ADDR_W-1:1], 1'b1};
        end
        if (op_q == OP_WRITE && state_q == C_ST_LOW) begin
            sram_dq_o = wdata_q[SRAM_DQ_W-1:0];
        end else if (op_q == OP_WRITE && state_q == C_ST_HIGH) begin
            sram_dq_o = wdata_q[DATA_W-1:SRAM_DQ_W];
        end
    end

    assign sram_dq_oe = (op_q == OP_WRITE) && w_active;
    assign sram_we_n  = ~sram_dq_oe;
    assign read_data  = rdata_q;
    assign ready      = (state_q == C_ST_DONE) || ((state_q == C_ST_IDLE) && !w_req);

endmodule
`default_nettype wire
